onebit_checker: RTL and testbench
=================================

Name: onebit_checker

Overview:
- Self-test sequencer and response checker for the `onebit` gate block.
- Drives the two `onebit` inputs through all four {a,b} combinations, one at a time.
- For each combination, samples the four `onebit` outputs (fa, fb, fc, fd) and compares them with a golden table.
- Reports per-vector failures, an error count, and pass/done status. Used as the synthesizable counterpart to the simulation-only stimulus bench, on board or in system simulation.

Parameters:
- SETTLE_CYC, 2, number of clock cycles each vector is held before its response is sampled; legal range 1..15.
- EXP, 16'h4934, golden response table. Bits EXP[4k+3:4k] = expected {fa,fb,fc,fd} for vector k. Default encodes {a>b, a==b, a<b, a!=b}.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to run one full check sequence.
- a  output  1  stimulus to onebit.a.
- b  output  1  stimulus to onebit.b.
- fa  input  1  onebit response.
- fb  input  1  onebit response.
- fc  input  1  onebit response.
- fd  input  1  onebit response.
- busy  output  1  high while the sequence is running.
- done  output  1  one-cycle pulse when results become valid.
- pass  output  1  1 when the last completed run had zero mismatches.
- err_cnt  output  3  number of mismatching vectors in the last run (0..4).
- fail_mask  output  4  bit k set when vector k mismatched in the last run.

Behaviour:
- Reset (rst=1 at a clk edge): all outputs go to 0 (a, b, busy, done, pass, err_cnt, fail_mask); state goes to IDLE. Reset overrides start in the same cycle.
- Vector order: k = 0, 1, 2, 3 with {a,b} = k[1:0]. a is the MSB, so a toggles at half the rate of b.
- States:
  - IDLE: a=b=0. If start=1 at an edge E0: state goes to RUN, k=0, hold counter=0, busy=1, pass/err_cnt/fail_mask cleared to 0, done=0.
  - RUN: a/b present vector k. The hold counter increments every cycle.
    - At the edge where the counter reaches SETTLE_CYC-1, {fa,fb,fc,fd} is sampled and compared with EXP nibble k.
    - On a mismatch, fail_mask[k] is set and err_cnt increments.
    - The counter then resets and k advances. a/b show vector k+1 immediately after that edge.
  - After vector 3 is sampled (edge E0 + 4*SETTLE_CYC): state goes to DONE, a=b=0, busy=0, done=1, pass = (err_cnt_final == 0).
  - DONE: lasts exactly one cycle, then returns to IDLE. done deasserts on the next edge.
- Each vector is visible for exactly SETTLE_CYC cycles. Total busy time is 4*SETTLE_CYC cycles.
- Compare logic: the sample uses the final count/mask, including the mismatch found on vector 3 at that same edge.
- Result persistence: pass, err_cnt and fail_mask hold their values after done until the next accepted start or reset.
- start while busy=1: ignored. It does not restart and does not affect results.
- start during the DONE cycle: ignored. start in the first IDLE cycle after DONE is accepted.
- rst during RUN: aborts immediately. Partial results are discarded and all outputs are 0.
- SETTLE_CYC=1: the sample happens on the first edge of each vector's window. There are no idle gaps between vectors.
- Inputs fa..fd are assumed combinational from a/b in the same clock domain; no synchronizers.

Test Plan:
1. Correct model (fa=a>b, fb=a==b, fc=a<b, fd=a!=b), SETTLE_CYC=2, start pulse at E0 -> a,b sequence 00,01,10,11, each held 2 cycles. done pulses at E0+8; pass=1, err_cnt=0, fail_mask=4'b0000; busy high for exactly 8 cycles.
2. Model with fd stuck at 1 -> vectors 0 and 3 fail. fail_mask=4'b1001, err_cnt=2, pass=0.
3. Model with fa and fc swapped -> vectors 1 and 2 fail. fail_mask=4'b0110, err_cnt=2. A following run with the correct model then clears to pass=1, err_cnt=0.
4. start re-asserted at E0+3 and E0+5 while busy -> no restart; done still occurs at E0+8 with the same results as scenario 1.
5. rst asserted at E0+5 in the middle of a run -> next cycle all outputs are 0 and state is IDLE. A new start then completes normally with pass=1.
6. SETTLE_CYC=1 instance, all-ones model (fa..fd=1111) -> every vector mismatches. done at E0+4, fail_mask=4'b1111, err_cnt=4, pass=0.

Source files
------------

// File: rtl/onebit_checker.sv
// Self-test sequencer for the onebit gate: walks {a,b} through 00..11,
// samples {fa,fb,fc,fd} after a settle window and scores against EXP.
module onebit_checker #(
    parameter int unsigned SETTLE_CYC = 2,
    parameter logic [15:0] EXP        = 16'h4934
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       fa,
    input  logic       fb,
    input  logic       fc,
    input  logic       fd,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [3:0] fail_mask
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYC - 1);

    state_e     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] err_q, err_d;
    logic [3:0] mask_q, mask_d;
    logic       pass_q, pass_d;

    logic [3:0] resp;
    logic [3:0] exp_nib;
    logic       mismatch;
    logic       sample;

    assign resp     = {fa, fb, fc, fd};
    assign exp_nib  = EXP[{vec_q, 2'b00} +: 4];
    assign mismatch = (resp != exp_nib);
    assign sample   = (cnt_q == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= 2'd0;
            cnt_q   <= 4'd0;
            err_q   <= 3'd0;
            mask_q  <= 4'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            mask_q  <= mask_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        mask_d  = mask_q;
        pass_d  = pass_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    vec_d   = 2'd0;
                    cnt_d   = 4'd0;
                    err_d   = 3'd0;
                    mask_d  = 4'd0;
                    pass_d  = 1'b0;
                end
            end
            RUN: begin
                if (sample) begin
                    cnt_d = 4'd0;
                    vec_d = vec_q + 2'd1;
                    if (mismatch) begin
                        mask_d[vec_q] = 1'b1;
                        err_d         = err_q + 3'd1;
                    end
                    // verdict must include the mismatch found on this edge
                    if (vec_q == 2'd3) begin
                        state_d = DONE;
                        pass_d  = (err_d == 3'd0);
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign a         = busy & vec_q[1];
    assign b         = busy & vec_q[0];
    assign pass      = pass_q;
    assign err_cnt   = err_q;
    assign fail_mask = mask_q;

endmodule

// File: tb/tb_onebit_checker.sv
// Scoreboard bench for onebit_checker: two instances (SETTLE 2 and 1)
// driven by a behavioural onebit model with injectable faults.
module tb_onebit_checker;

    typedef struct {
        int         dc;
        logic       pass;
        logic [2:0] err;
        logic [3:0] mask;
    } exp_t;

    logic       clk = 1'b0;
    logic [1:0] rst = 2'b11;
    logic [1:0] start = 2'b00;
    logic [1:0] a_s, b_s, busy_s, done_s, pass_s;
    logic [2:0] err_s [2];
    logic [3:0] mask_s [2];
    logic [3:0] f_s [2];
    int         mode [2];
    logic [15:0] xt [2];

    int         cyc = 0;
    logic [1:0] rst_seen = 2'b11;
    logic [1:0] dprev = 2'b00;
    int         total = 0;
    int         bad = 0;

    exp_t       sb [2][$];
    logic [1:0] tr [2][$];
    int         bc [2];
    logic       lp [2];
    logic [2:0] le [2];
    logic [3:0] lm [2];

    always #5 clk = ~clk;

    onebit_checker #(.SETTLE_CYC(2)) u_s2 (
        .clk(clk), .rst(rst[0]), .start(start[0]),
        .a(a_s[0]), .b(b_s[0]),
        .fa(f_s[0][3]), .fb(f_s[0][2]), .fc(f_s[0][1]), .fd(f_s[0][0]),
        .busy(busy_s[0]), .done(done_s[0]), .pass(pass_s[0]),
        .err_cnt(err_s[0]), .fail_mask(mask_s[0])
    );

    onebit_checker #(.SETTLE_CYC(1)) u_s1 (
        .clk(clk), .rst(rst[1]), .start(start[1]),
        .a(a_s[1]), .b(b_s[1]),
        .fa(f_s[1][3]), .fb(f_s[1][2]), .fc(f_s[1][1]), .fd(f_s[1][0]),
        .busy(busy_s[1]), .done(done_s[1]), .pass(pass_s[1]),
        .err_cnt(err_s[1]), .fail_mask(mask_s[1])
    );

    function automatic int settle(int i);
        return (i == 0) ? 2 : 1;
    endfunction

    // ideal gate outputs {a>b, a==b, a<b, a!=b} for vector k={a,b}
    function automatic logic [3:0] golden(int k);
        int av;
        int bv;
        av = k / 2;
        bv = k % 2;
        return {av > bv, av == bv, av < bv, av != bv};
    endfunction

    function automatic logic [3:0] resp(int m, logic [15:0] x, int k);
        logic [3:0] g;
        g = golden(k);
        case (m)
            1: return g | 4'b0001;
            2: return {g[1], g[2], g[3], g[0]};
            3: return 4'b1111;
            4: return g ^ x[4*k +: 4];
            default: return g;
        endcase
    endfunction

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            f_s[i] = resp(mode[i], xt[i], int'({a_s[i], b_s[i]}));
        end
    end

    task automatic chk(int i, string nm, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL inst%0d %s cyc=%0d got=%0h want=%0h",
                     i, nm, cyc, act, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    // monitor: pops the scoreboard on done, checks every other cycle too
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst_seen[i]) begin
                sb[i].delete();
                tr[i].delete();
                bc[i] = 0;
                lp[i] = 1'b0;
                le[i] = 3'd0;
                lm[i] = 4'd0;
                chk(i, "rst_outs", int'({a_s[i], b_s[i], busy_s[i],
                    done_s[i], pass_s[i], err_s[i], mask_s[i]}), 0);
            end else if (done_s[i]) begin
                chk(i, "done_once", int'(dprev[i]), 0);
                chk(i, "done_ab_busy",
                    int'({a_s[i], b_s[i], busy_s[i]}), 0);
                if (sb[i].size() == 0) begin
                    chk(i, "unexp_done", 1, 0);
                end else begin
                    exp_t e;
                    int s;
                    e = sb[i].pop_front();
                    s = settle(i);
                    chk(i, "done_cyc", cyc, e.dc);
                    chk(i, "pass", int'(pass_s[i]), int'(e.pass));
                    chk(i, "err_cnt", int'(err_s[i]), int'(e.err));
                    chk(i, "fail_mask", int'(mask_s[i]), int'(e.mask));
                    chk(i, "busy_len", bc[i], 4 * s);
                    chk(i, "trace_len", tr[i].size(), 4 * s);
                    for (int j = 0; j < tr[i].size() && j < 4 * s; j++) begin
                        chk(i, "vec_seq", int'(tr[i][j]), j / s);
                    end
                    lp[i] = e.pass;
                    le[i] = e.err;
                    lm[i] = e.mask;
                end
                tr[i].delete();
                bc[i] = 0;
            end else if (busy_s[i]) begin
                bc[i]++;
                tr[i].push_back({a_s[i], b_s[i]});
                chk(i, "busy_pass", int'(pass_s[i]), 0);
            end else begin
                chk(i, "idle_hold",
                    int'({a_s[i], b_s[i], pass_s[i], err_s[i], mask_s[i]}),
                    int'({2'b00, lp[i], le[i], lm[i]}));
            end
            dprev[i] = done_s[i] & ~rst_seen[i];
        end
    end

    task automatic push_exp(int i, int dc);
        exp_t e;
        int n;
        logic [3:0] msk;
        n = 0;
        msk = 4'd0;
        for (int k = 0; k < 4; k++) begin
            if (resp(mode[i], xt[i], k) != golden(k)) begin
                n++;
                msk[k] = 1'b1;
            end
        end
        e.dc   = dc;
        e.pass = (n == 0);
        e.err  = 3'(n);
        e.mask = msk;
        sb[i].push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(int i);
        push_exp(i, cyc + 1 + 4 * settle(i));
        start[i] = 1'b1;
        tick();
        start[i] = 1'b0;
    endtask

    task automatic wait_idle(int i);
        int n;
        n = 0;
        while (sb[i].size() != 0 && n < 200) begin
            tick();
            n++;
        end
        chk(i, "drain", sb[i].size(), 0);
        sb[i].delete();
        tick();
    endtask

    task automatic run(int i, int m, logic [15:0] x);
        mode[i] = m;
        xt[i] = x;
        issue(i);
        wait_idle(i);
    endtask

    initial begin
        mode[0] = 0;
        mode[1] = 0;
        xt[0] = 16'd0;
        xt[1] = 16'd0;
        repeat (3) tick();
        rst = 2'b00;
        tick();

        run(0, 0, 16'd0);
        run(0, 1, 16'd0);
        run(0, 2, 16'd0);
        run(0, 0, 16'd0);

        // start pulses while busy must be ignored
        mode[0] = 0;
        issue(0);
        repeat (2) tick();
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        tick();
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        wait_idle(0);

        // abort mid-run, then a clean run
        issue(0);
        repeat (4) tick();
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        repeat (2) tick();
        run(0, 0, 16'd0);

        run(1, 3, 16'd0);

        // start held across DONE: ignored in DONE, taken in next IDLE
        mode[1] = 0;
        issue(1);
        repeat (4) tick();
        start[1] = 1'b1;
        push_exp(1, cyc + 2 + 4);
        repeat (2) tick();
        start[1] = 1'b0;
        wait_idle(1);

        for (int n = 0; n < 16; n++) begin
            int m;
            m = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 4;
            run(n % 2, m, 16'($urandom));
        end

        repeat (3) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
